// File: rtl/ex_mem_stage_buf_if.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_buf_if
//   Valid/ready bus used on both sides of the EX->MEM stage register.
//   One instance carries EX -> stage traffic; a second carries stage -> MEM.
//
//   Signals
//     valid       producer has a valid instruction on the bus
//     ready       consumer accepts this cycle
//     wm          write/memory control bits      (WM_W)
//     alu_result  ALU result / memory address    (XLEN)
//     store_data  forwarded store data           (XLEN)
//     rd          destination register number    (REG_W)
//
//   Modports
//     master  drives valid and the payload; samples ready
//     slave   samples valid and the payload; drives ready
// ---------------------------------------------------------------------------
interface ex_mem_stage_buf_if #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5,
  parameter int WM_W  = 5
) ();

  logic             valid;
  logic             ready;
  logic [WM_W-1:0]  wm;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  store_data;
  logic [REG_W-1:0] rd;

  modport master (
    output valid,
    output wm,
    output alu_result,
    output store_data,
    output rd,
    input  ready
  );

  modport slave (
    input  valid,
    input  wm,
    input  alu_result,
    input  store_data,
    input  rd,
    output ready
  );

endinterface : ex_mem_stage_buf_if

// File: rtl/ex_mem_stage_buf.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_buf
//   EX->MEM pipeline stage register with valid/ready flow control, flush
//   (bubble injection) and an optional 2-entry skid buffer. Sustains one
//   transfer per clock.
//
//   Parameters
//     XLEN        width of alu_result / store_data
//     REG_W       width of the destination register number
//     WM_W        width of the write/memory control field
//     SKID        1: main + skid entry, in_ready comes from state only
//                 0: single entry, in_ready = ~main_valid | out_ready
//     ZERO_BUBBLE 1: out payload forced to zero while out_valid = 0
//                 0: out payload shows the last value held in main
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     flush      drop every held entry and any same-cycle accept
//     in_bus     EX side   (slave modport: valid/payload in, ready out)
//     out_bus    MEM side  (master modport: valid/payload out, ready in)
//     occupancy  number of entries held (0, 1, or 2 with SKID=1)
// ---------------------------------------------------------------------------
module ex_mem_stage_buf #(
  parameter int XLEN        = 64,
  parameter int REG_W       = 5,
  parameter int WM_W        = 5,
  parameter bit SKID        = 1'b1,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  ex_mem_stage_buf_if.slave  in_bus,
  ex_mem_stage_buf_if.master out_bus,
  output logic [1:0]         occupancy
);

  // One held instruction: every field travels bit-exact.
  typedef struct packed {
    logic [WM_W-1:0]  wm;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] rd;
  } payload_t;

  // EMPTY: nothing held; ONE: main valid; TWO: main and skid valid.
  // TWO is only reachable when SKID=1.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t   state_r;
  state_t   state_nxt_s;
  payload_t main_r;
  payload_t skid_r;
  payload_t in_payload_s;

  logic main_valid_s;
  logic skid_valid_s;
  logic in_ready_s;
  logic accept_s;
  logic deliver_s;
  logic load_main_in_s;
  logic load_main_skid_s;
  logic load_skid_s;

  assign in_payload_s = '{
    wm:         in_bus.wm,
    alu_result: in_bus.alu_result,
    store_data: in_bus.store_data,
    rd:         in_bus.rd
  };

  assign main_valid_s = (state_r != S_EMPTY);
  assign skid_valid_s = (state_r == S_TWO);

  // Ready toward EX: SKID=1 depends only on state (no path from out_ready);
  // SKID=0 may take a new entry in the same cycle the old one leaves.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID) begin
      in_ready_s = (state_r != S_TWO);
    end else begin
      in_ready_s = (state_r == S_EMPTY) || out_bus.ready;
    end
  end

  assign accept_s  = in_bus.valid && in_ready_s;
  assign deliver_s = main_valid_s && out_bus.ready;

  // Next-state and payload load strobes; flush wins over every transfer.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nxt_s = S_EMPTY;
    end else begin
      case (state_r)
        S_EMPTY: begin
          if (accept_s) begin
            load_main_in_s = 1'b1;
            state_nxt_s    = S_ONE;
          end else begin
            state_nxt_s    = S_EMPTY;
          end
        end
        S_ONE: begin
          if (deliver_s && accept_s) begin
            load_main_in_s = 1'b1;
            state_nxt_s    = S_ONE;
          end else if (deliver_s) begin
            state_nxt_s    = S_EMPTY;
          end else if (accept_s && SKID) begin
            // Main is stalled: park the newcomer in the skid entry.
            load_skid_s    = 1'b1;
            state_nxt_s    = S_TWO;
          end else begin
            state_nxt_s    = S_ONE;
          end
        end
        S_TWO: begin
          if (deliver_s) begin
            load_main_skid_s = 1'b1;
            state_nxt_s      = S_ONE;
          end else begin
            state_nxt_s      = S_TWO;
          end
        end
        default: begin
          state_nxt_s = S_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Main payload: loads from EX on accept or from skid when skid drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r <= '0;
    end else if (load_main_in_s) begin
      main_r <= in_payload_s;
    end else if (load_main_skid_s) begin
      main_r <= skid_r;
    end else begin
      main_r <= main_r;
    end
  end

  // Skid payload: loads only when main is stalled and a new entry arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_r <= '0;
    end else if (load_skid_s) begin
      skid_r <= in_payload_s;
    end else begin
      skid_r <= skid_r;
    end
  end

  assign in_bus.ready = in_ready_s;
  assign out_bus.valid = main_valid_s;

  // Outputs are decoded from registers only; with ZERO_BUBBLE an empty
  // stage presents an all-zero NOP so MEM performs no writes.
  always_comb begin
    if (ZERO_BUBBLE && !main_valid_s) begin
      out_bus.wm         = '0;
      out_bus.alu_result = '0;
      out_bus.store_data = '0;
      out_bus.rd         = '0;
    end else begin
      out_bus.wm         = main_r.wm;
      out_bus.alu_result = main_r.alu_result;
      out_bus.store_data = main_r.store_data;
      out_bus.rd         = main_r.rd;
    end
  end

  assign occupancy = {1'b0, main_valid_s} + {1'b0, skid_valid_s};

endmodule : ex_mem_stage_buf

// File: tb/tb_ex_mem_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_buf
//   Two instances: u_a (SKID=1, ZERO_BUBBLE=1) and u_b (SKID=0,
//   ZERO_BUBBLE=0). A queue model per instance predicts every output each
//   cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_buf;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;
  localparam int WM_W  = 5;

  typedef struct packed {
    logic [WM_W-1:0]  wm;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  sd;
    logic [REG_W-1:0] rd;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_a;
  logic       flush_b;
  logic [1:0] occ_a;
  logic [1:0] occ_b;

  int total = 0;
  int bad   = 0;

  ex_mem_stage_buf_if #(.XLEN(XLEN), .REG_W(REG_W), .WM_W(WM_W)) in_a ();
  ex_mem_stage_buf_if #(.XLEN(XLEN), .REG_W(REG_W), .WM_W(WM_W)) out_a ();
  ex_mem_stage_buf_if #(.XLEN(XLEN), .REG_W(REG_W), .WM_W(WM_W)) in_b ();
  ex_mem_stage_buf_if #(.XLEN(XLEN), .REG_W(REG_W), .WM_W(WM_W)) out_b ();

  always #5 clk = ~clk;

  ex_mem_stage_buf #(
    .XLEN(XLEN), .REG_W(REG_W), .WM_W(WM_W), .SKID(1'b1), .ZERO_BUBBLE(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_bus(in_a), .out_bus(out_a), .occupancy(occ_a)
  );

  ex_mem_stage_buf #(
    .XLEN(XLEN), .REG_W(REG_W), .WM_W(WM_W), .SKID(1'b0), .ZERO_BUBBLE(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_bus(in_b), .out_bus(out_b), .occupancy(occ_b)
  );

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: FIFO of held entries ----------------
  ent_t qa[$];
  ent_t qb[$];
  ent_t last_b;   // u_b shows the last head when empty (no zero bubble)

  always @(posedge rst) begin
    qa.delete();
    qb.delete();
    last_b = '0;
  end

  always @(posedge clk) begin
    if (!rst) begin : upd
      bit acc;
      bit del;
      del = (qa.size() > 0) && out_a.ready;
      acc = in_a.valid && (qa.size() < 2);
      if (flush_a) qa.delete();
      else begin
        if (del) void'(qa.pop_front());
        if (acc) qa.push_back('{in_a.wm, in_a.alu_result, in_a.store_data, in_a.rd});
      end
      del = (qb.size() > 0) && out_b.ready;
      acc = in_b.valid && ((qb.size() == 0) || out_b.ready);
      if (flush_b) qb.delete();
      else begin
        if (del) void'(qb.pop_front());
        if (acc) qb.push_back('{in_b.wm, in_b.alu_result, in_b.store_data, in_b.rd});
      end
      if (qb.size() > 0) last_b = qb[0];
    end
  end

  // ---------------- compare process: every cycle, on the falling edge ------
  always @(negedge clk) begin : cmp
    ent_t ea;
    ent_t eb;
    ea = (qa.size() > 0) ? qa[0] : '0;
    eb = (qb.size() > 0) ? qb[0] : last_b;
    chk("a_valid", 64'(out_a.valid), 64'(qa.size() > 0));
    chk("a_ready", 64'(in_a.ready), 64'(qa.size() < 2));
    chk("a_occ",   64'(occ_a), 64'(qa.size()));
    chk("a_wm",    64'(out_a.wm), 64'(ea.wm));
    chk("a_alu",   out_a.alu_result, ea.alu);
    chk("a_sd",    out_a.store_data, ea.sd);
    chk("a_rd",    64'(out_a.rd), 64'(ea.rd));
    chk("b_valid", 64'(out_b.valid), 64'(qb.size() > 0));
    chk("b_ready", 64'(in_b.ready), 64'((qb.size() == 0) || out_b.ready));
    chk("b_occ",   64'(occ_b), 64'(qb.size()));
    chk("b_wm",    64'(out_b.wm), 64'(eb.wm));
    chk("b_alu",   out_b.alu_result, eb.alu);
    chk("b_sd",    out_b.store_data, eb.sd);
    chk("b_rd",    64'(out_b.rd), 64'(eb.rd));
  end

  task automatic drive_a(input logic v, input logic [XLEN-1:0] alu, input logic [REG_W-1:0] rd);
    in_a.valid      = v;
    in_a.alu_result = alu;
    in_a.store_data = ~alu;
    in_a.wm         = WM_W'(alu[3:0]) ^ 5'h10;
    in_a.rd         = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drive_a(1'b0, 64'd0, 5'd0);
    out_a.ready = 1'b0;
    in_b.valid = 1'b0;
    in_b.wm = '0;
    in_b.alu_result = '0;
    in_b.store_data = '0;
    in_b.rd = '0;
    out_b.ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // 1. Async reset while holding two entries.
    drive_a(1'b1, 64'h11, 5'd1);
    step();
    drive_a(1'b1, 64'h22, 5'd2);
    step();
    drive_a(1'b0, 64'h0, 5'd0);
    chk("t1_occ_before", 64'(occ_a), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("t1_valid_now", 64'(out_a.valid), 64'd0);
    chk("t1_occ_now", 64'(occ_a), 64'd0);
    chk("t1_alu_now", out_a.alu_result, 64'd0);
    chk("t1_ready_now", 64'(in_a.ready), 64'd1);
    drive_a(1'b1, 64'h33, 5'd3);   // dropped: arrives while in reset
    step();
    rst = 1'b0;
    drive_a(1'b0, 64'h0, 5'd0);
    step();
    chk("t1_occ_after", 64'(occ_a), 64'd0);

    // 2. Streaming: 8 back-to-back with out_ready=1.
    out_a.ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        chk("t2_alu", out_a.alu_result, 64'(i - 1));
        chk("t2_rd", 64'(out_a.rd), 64'(i - 1));
        chk("t2_ready", 64'(in_a.ready), 64'd1);
      end
      if (i <= 8) drive_a(1'b1, 64'(i), 5'(i));
      else drive_a(1'b0, 64'd0, 5'd0);
      step();
    end
    chk("t2_drained", 64'(out_a.valid), 64'd0);

    // 3. Stall with skid: A, B fill, C held upstream.
    out_a.ready = 1'b0;
    drive_a(1'b1, 64'hAAAA, 5'd10);
    step();
    drive_a(1'b1, 64'hBBBB, 5'd11);
    step();
    drive_a(1'b1, 64'hCCCC, 5'd12);
    chk("t3_occ2", 64'(occ_a), 64'd2);
    chk("t3_ready0", 64'(in_a.ready), 64'd0);
    step();
    step();
    chk("t3_hold_occ", 64'(occ_a), 64'd2);
    chk("t3_head_a", out_a.alu_result, 64'hAAAA);
    out_a.ready = 1'b1;
    step();
    chk("t3_head_b", out_a.alu_result, 64'hBBBB);
    step();
    chk("t3_head_c", out_a.alu_result, 64'hCCCC);
    drive_a(1'b0, 64'd0, 5'd0);
    step();
    chk("t3_empty", 64'(out_a.valid), 64'd0);

    // 4. Flush in TWO with in_valid=1.
    out_a.ready = 1'b0;
    drive_a(1'b1, 64'hD0D0, 5'd13);
    step();
    drive_a(1'b1, 64'hE0E0, 5'd14);
    step();
    drive_a(1'b1, 64'hF0F0, 5'd15);
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    drive_a(1'b0, 64'd0, 5'd0);
    chk("t4_valid", 64'(out_a.valid), 64'd0);
    chk("t4_occ", 64'(occ_a), 64'd0);
    chk("t4_ready", 64'(in_a.ready), 64'd1);
    chk("t4_alu", out_a.alu_result, 64'd0);
    out_a.ready = 1'b1;
    step();
    chk("t4_no_ghost", 64'(out_a.valid), 64'd0);

    // 5. Random traffic on both instances (model checks every cycle).
    for (int c = 0; c < 1000; c++) begin
      drive_a(1'($urandom_range(0, 9) < 7), {$urandom, $urandom}, 5'($urandom));
      in_a.store_data = {$urandom, $urandom};
      in_a.wm         = 5'($urandom);
      out_a.ready     = 1'($urandom_range(0, 9) < 6);
      flush_a         = 1'($urandom_range(0, 39) == 0);
      in_b.valid      = 1'($urandom_range(0, 9) < 6);
      in_b.alu_result = {$urandom, $urandom};
      in_b.store_data = {$urandom, $urandom};
      in_b.wm         = 5'($urandom);
      in_b.rd         = 5'($urandom);
      out_b.ready     = 1'($urandom_range(0, 9) < 5);
      flush_b         = 1'($urandom_range(0, 39) == 0);
      step();
    end
    drive_a(1'b0, 64'd0, 5'd0);
    flush_a = 1'b0;
    in_b.valid = 1'b0;
    flush_b = 1'b1;
    step();
    flush_b = 1'b0;

    // 6. No zero bubble: rd=5 delivered, then idle keeps showing it.
    out_b.ready = 1'b1;
    in_b.valid = 1'b1;
    in_b.rd = 5'd5;
    in_b.alu_result = 64'h55;
    step();
    in_b.valid = 1'b0;
    chk("t6_valid1", 64'(out_b.valid), 64'd1);
    chk("t6_rd_live", 64'(out_b.rd), 64'd5);
    step();
    chk("t6_valid0", 64'(out_b.valid), 64'd0);
    chk("t6_rd_hold", 64'(out_b.rd), 64'd5);
    step();
    chk("t6_rd_hold2", 64'(out_b.rd), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ex_mem_stage_buf
